vga_fb_arbiter: RTL
===================

# vga_fb_arbiter

Shares one single-port framebuffer RAM between VGA scanout and GPU pixel writes. The block sits between the VGA sync generator (pos_x/pos_y/blank_n/h_sync/v_sync), the GPU write port and the framebuffer RAM. A small write queue absorbs GPU writes. Scanout reads always win the RAM. Sync and blank signals are delayed so that they stay aligned with the fetched pixel colour.

## Interface
- FB_W, 128: framebuffer width in logical pixels (power of two)
- FB_H, 32: framebuffer height in logical pixels
- ADDR_W, 12: RAM address width, log2(FB_W*FB_H)
- DATA_W, 8: pixel colour width
- DEPTH, 4: write-queue entries (power of two)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pos_x  in  10  logical pixel x from sync generator
- pos_y  in  10  logical pixel y from sync generator
- blank_n  in  1  1 = active video
- h_sync, v_sync  in  1 each  sync pulses from generator
- hs_out, vs_out, blank_n_out  out  1 each  inputs delayed 2 cycles
- pix_color  out  DATA_W  colour aligned with blank_n_out
- wr_valid  in  1  GPU write request
- wr_ready  out  1  queue can accept
- wr_addr  in  ADDR_W  target pixel address, y*FB_W+x
- wr_data  in  DATA_W  colour to write
- wq_empty  out  1  all accepted writes committed to RAM
- ram_en, ram_we  out  1 each  RAM strobe / write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after read strobe

## Operation
- **Write queue:** DEPTH-entry FIFO of {addr, data}.
  - wr_ready = rst_n & ~full. Push on wr_valid & wr_ready.
  - Push and pop in the same cycle leave the level unchanged.
  - A push when full is impossible, even if a pop occurs in that cycle.
  - wq_empty = queue empty and no write in flight.
- **Fetch address:** fa = pos_y[log2 FB_H-1:0]*FB_W + pos_x[log2 FB_W-1:0]. The address is in range when pos_x < FB_W and pos_y < FB_H.
- **Read request:** read_req = blank_n & in_range & (~last_vld | fa != last_addr). On a read, last_addr <= fa and last_vld <= 1. blank_n=0 clears last_vld, so the first pixel of every line is refetched.
- **Slot arbitration (per cycle, combinational to RAM):**
  - READ: read_req=1 drives ram_en=1, ram_we=0, ram_addr=fa.
  - WRITE: read_req=0 and queue not empty drives ram_en=1, ram_we=1, and the head entry on ram_addr/ram_wdata. The head pops.
  - IDLE: otherwise, ram_en=0.
- A read always beats a pending write. Writes commit in FIFO order.
- There is no read-after-write ordering with scanout: a write to the pixel on display appears on the next fetch of that pixel.
- **Pixel path:**
  - Stage 1 registers rd_issued.
  - Stage 2: pix_color <= ram_rdata if rd_issued. It holds its previous value when active but no new fetch. It becomes 0 when the delayed blank_n=0 or the delayed in_range=0.
- **Sync delay:** h_sync, v_sync, blank_n and in_range each pass through a 2-stage delay.

## Timing
- **Reset (async assert):**
  - Queue emptied, pending writes discarded.
  - last_vld=0; pix_color=0; hs_out, vs_out, blank_n_out=0; wq_empty=1.
  - ram_en, ram_we and wr_ready are forced to 0 combinationally while rst_n=0.
- **Write latency:** push at cycle N makes the earliest ram_we cycle N+1. A read slot in N+1 delays it to N+2 or later.
- **Read latency:** fa changes at cycle N, so ram_en occurs in N, ram_rdata in N+1, and pix_color updates at the N+2 edge. blank_n_out/hs_out/vs_out follow inputs with the same 2-cycle latency.
- **Read bandwidth:** with standard sync input, pos_x changes every 5 clocks, so at most 1 read per 5 cycles. The queue drains at ≥4 writes per 5 cycles in active video and 1 per cycle in blanking.
- **Wrap-around:** FIFO pointers are log2(DEPTH)+1 bits, so full and empty are distinguished by the MSB.
- **Reset mid-operation:** state is lost immediately. The first cycle after release behaves as a fresh frame.

## Test plan
- **Reset:** hold rst_n=0 with wr_valid=1 and blank_n=1. Expect wr_ready=0, ram_en=0, pix_color=0, wq_empty=1. Release; at the next edge wr_ready=1.
- **Single write:** blank_n=0; push addr 0x085, data 0x3C at cycle N. Expect ram_en=1, ram_we=1, ram_addr=0x085, ram_wdata=0x3C at N+1, and wq_empty=1 at N+2.
- **Scanout:** blank_n=1, pos=(1,2) held 5 cycles, ram_rdata=0xA5. Expect exactly one read at ram_addr=0x101. pix_color=0xA5 from the 2nd edge on, with blank_n_out aligned.
- **Contention:** push a write in the same cycle pos changes. Expect the read in N+1 if the write is queued; the write commits one cycle later. Order of 3 back-to-back writes is preserved.
- **Full:** bench changes pos every cycle with blank_n=1 (reads every cycle) and pushes 5 writes. Expect 4 accepted and wr_ready=0 after the 4th. Drop blank_n: the queue drains 4 writes in 4 cycles and wr_ready returns to 1.
- **Reset mid-queue:** 3 entries queued; pulse rst_n low 1 cycle. Expect no further ram_we and wq_empty=1.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// GPU write port of the framebuffer arbiter: valid/ready pixel writes plus
// the "everything committed" status flag.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wq_empty;

    // GPU side: issues writes, watches back-pressure and drain status.
    modport master (
        output wr_valid, wr_addr, wr_data,
        input  wr_ready, wq_empty
    );

    // Arbiter side: accepts writes into its queue.
    modport slave (
        input  wr_valid, wr_addr, wr_data,
        output wr_ready, wq_empty
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between VGA scanout
// reads and GPU pixel writes. Scanout reads always win the RAM slot; GPU
// writes wait in a small FIFO and commit in order whenever no read is due.
// Sync/blank are delayed two cycles so they line up with the fetched colour.
module vga_fb_arbiter #(
    parameter int FB_W   = 128,
    parameter int FB_H   = 32,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              blank_n,
    input  logic              h_sync,
    input  logic              v_sync,
    output logic              hs_out,
    output logic              vs_out,
    output logic              blank_n_out,
    output logic [DATA_W-1:0] pix_color,
    vga_fb_arbiter_if.slave   wr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int XW = $clog2(FB_W);
    localparam int YW = $clog2(FB_H);
    localparam int PW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit: equal means empty, differing only
    // in the wrap bit means full.
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);
    localparam logic [PW:0] PTR_MSB = (PW+1)'(DEPTH);

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_READ,
        SLOT_WRITE
    } slot_e;

    // ------------------------------------------------------------------
    // Write queue
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] q_addr [DEPTH];
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [PW:0]       wptr;
    logic [PW:0]       rptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    slot_e             slot;

    assign empty       = (wptr == rptr);
    assign full        = ((wptr ^ rptr) == PTR_MSB);
    assign wr.wr_ready = rst_n & ~full;
    assign wr.wq_empty = empty;
    assign push        = wr.wr_valid & wr.wr_ready;
    assign pop         = (slot == SLOT_WRITE);

    // Queue pointers: advance on push/pop, cleared by reset.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Queue storage: capture the accepted {addr, data} at the write pointer.
    // NOTE: the storage array is deliberately not reset; an entry is only
    // read after it has been pushed, so the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr[PW-1:0]] <= wr.wr_addr;
            q_data[wptr[PW-1:0]] <= wr.wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Scanout fetch address and read request
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] fa;
    logic              in_range;
    logic              read_req;
    logic [ADDR_W-1:0] last_addr;
    logic              last_vld;

    // FB_W is a power of two, so y*FB_W + x is a plain concatenation.
    assign fa       = ADDR_W'({pos_y[YW-1:0], pos_x[XW-1:0]});
    assign in_range = (pos_x < 10'(FB_W)) && (pos_y < 10'(FB_H));
    assign read_req = blank_n & in_range & (~last_vld | (fa != last_addr));

    // Remember the last fetched address so a held pixel is read only once;
    // blanking forgets it so each line's first pixel is refetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld  <= 1'b0;
            last_addr <= '0;
        end else if (read_req) begin
            last_vld  <= 1'b1;
            last_addr <= fa;
        end else if (!blank_n) begin
            last_vld  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Slot arbitration: read beats write, otherwise idle
    // ------------------------------------------------------------------
    // Pick this cycle's RAM slot and drive the RAM port from it.
    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        slot      = SLOT_IDLE;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = fa;
        ram_wdata = q_data[rptr[PW-1:0]];
        if (rst_n) begin
            if (read_req)    slot = SLOT_READ;
            else if (!empty) slot = SLOT_WRITE;
        end
        case (slot)
            SLOT_READ: begin
                ram_en = 1'b1;
            end
            SLOT_WRITE: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = q_addr[rptr[PW-1:0]];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel / sync pipeline
    // ------------------------------------------------------------------
    logic rd_issued;
    logic blank_d1;
    logic in_range_d1;
    logic hs_d1;
    logic vs_d1;

    // Stage 1: note whether a read went out and delay the video controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_issued   <= 1'b0;
            blank_d1    <= 1'b0;
            in_range_d1 <= 1'b0;
            hs_d1       <= 1'b0;
            vs_d1       <= 1'b0;
        end else begin
            rd_issued   <= (slot == SLOT_READ);
            blank_d1    <= blank_n;
            in_range_d1 <= in_range;
            hs_d1       <= h_sync;
            vs_d1       <= v_sync;
        end
    end

    // Stage 2: capture fetched colour (hold between fetches, black outside
    // active in-range video) alongside the twice-delayed controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_color   <= '0;
            blank_n_out <= 1'b0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
        end else begin
            blank_n_out <= blank_d1;
            hs_out      <= hs_d1;
            vs_out      <= vs_d1;
            if (!blank_d1 || !in_range_d1) pix_color <= '0;
            else if (rd_issued)            pix_color <= ram_rdata;
        end
    end
endmodule
